// File: rtl/led_request_arbiter.sv
// LED ownership arbiter: three requesters (fault has priority) share four LEDs.
// Break-before-make hand-over through a one-cycle GAP, with tick-based fairness hold.
module led_request_arbiter #(
    parameter int unsigned TICK_DIV   = 16_666_666,
    parameter int unsigned HOLD_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [3:0] pat0,
    input  logic [3:0] pat1,
    input  logic [3:0] pat2,
    output logic [2:0] gnt,
    output logic [3:0] leds,
    output logic       tick,
    output logic       busy
);

    // state | meaning
    // IDLE  | no owner, LEDs dark, arbitrate on any request
    // OWN   | one requester drives the LEDs
    // GAP   | single dark cycle between owners, then arbitrate
    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [3:0] HOLD_MAX = 4'(HOLD_TICKS);

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [3:0]    hold;
    logic          rr_ptr, rr_n;
    logic [2:0]    gnt_n, sel;
    logic [3:0]    leds_n, sel_pat, owner_pat;
    logic          owner_req, other_req, hold_done;

    always_comb begin
        sel = 3'b000;
        if (req[2])
            sel = 3'b100;
        else if (req[1] && req[0])
            sel = rr_ptr ? 3'b010 : 3'b001;
        else if (req[1])
            sel = 3'b010;
        else if (req[0])
            sel = 3'b001;
    end

    always_comb begin
        sel_pat = pat0;
        if (sel[2])
            sel_pat = pat2;
        else if (sel[1])
            sel_pat = pat1;
    end

    always_comb begin
        owner_pat = pat0;
        if (gnt[2])
            owner_pat = pat2;
        else if (gnt[1])
            owner_pat = pat1;
    end

    assign owner_req = |(gnt & req);
    assign other_req = |(req & ~gnt);
    assign hold_done = (hold == HOLD_MAX);
    assign busy      = (state != IDLE);

    always_comb begin
        state_n = state;
        gnt_n   = 3'b000;
        leds_n  = 4'b0000;
        rr_n    = rr_ptr;
        case (state)
            IDLE, GAP: begin
                if (|req) begin
                    state_n = OWN;
                    gnt_n   = sel;
                    leds_n  = sel_pat;
                    if (sel[0]) rr_n = 1'b1;
                    if (sel[1]) rr_n = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            OWN: begin
                // Fault owner is never preempted; normal owners yield to fault at once
                // and to the other normal requester once the hold has expired.
                if (!owner_req || (!gnt[2] && (req[2] || (other_req && hold_done)))) begin
                    state_n = GAP;
                end else begin
                    gnt_n  = gnt;
                    leds_n = owner_pat;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            tick <= (cnt == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= 3'b000;
            leds   <= 4'b0000;
            rr_ptr <= 1'b0;
            hold   <= 4'd0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            leds   <= leds_n;
            rr_ptr <= rr_n;
            if (state != OWN && state_n == OWN)
                hold <= 4'd0;
            else if (state == OWN && tick && !hold_done)
                hold <= hold + 4'd1;
        end
    end

endmodule

// File: doc/led_request_arbiter.md
LED_REQUEST_ARBITER -- requirements
Module: led_request_arbiter

Interface
REQ-001 Parameter TICK_DIV, default 16_666_666: clk cycles per tick (~0.33 s at 50 MHz); legal range 1..2^24.
REQ-002 Parameter HOLD_TICKS, default 3: minimum ticks an owner keeps the LEDs before a contending requester may take them; legal range 0..15.
REQ-003 clk  input  1  fabric clock, 50 MHz.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  3  per-requester request; bit 2 = fault (highest priority), bits 1:0 = normal requesters.
REQ-006 pat0, pat1, pat2  input  4 each  LED pattern supplied by requester 0/1/2.
REQ-007 gnt  output  3  registered one-hot grant; all-zero when no owner.
REQ-008 leds  output  4  registered LED drive.
REQ-009 tick  output  1  registered single-cycle pulse, once every TICK_DIV cycles.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 Tick counter SHALL count 0..TICK_DIV-1 freely from reset, independent of state; tick SHALL be 1 in the cycle after the counter reaches TICK_DIV-1; TICK_DIV=1 SHALL give tick high every cycle after the first.
REQ-012 FSM states SHALL be IDLE, OWN and GAP.
REQ-013 IDLE: gnt=0, leds=0; if any req bit is high, the next edge SHALL enter OWN with gnt set to the selected requester and leds loaded from its pattern (1-cycle req-to-gnt latency).
REQ-014 Selection SHALL be: req[2] if set; otherwise the single requester of req[1:0] that is set; if both are set, the one not most recently granted (round-robin pointer).
REQ-015 Round-robin pointer SHALL update only when requester 0 or 1 is granted; after reset requester 0 wins a 0/1 tie.
REQ-016 OWN: leds SHALL follow the owner's pattern with one register stage (leds = pattern sampled on previous edge).
REQ-017 OWN: hold counter SHALL clear on entry, increment on each tick, and saturate at HOLD_TICKS.
REQ-018 OWN -> GAP when the owner's req deasserts.
REQ-019 OWN -> GAP when owner is 0 or 1, another req bit is set, and hold counter equals HOLD_TICKS (fairness preemption); HOLD_TICKS=0 allows this on the first OWN cycle.
REQ-020 OWN -> GAP immediately when req[2] rises while owner is 0 or 1, regardless of hold counter.
REQ-021 Owner 2 SHALL never be preempted; it leaves OWN only by deasserting req[2].
REQ-022 GAP SHALL last exactly one cycle with gnt=0 and leds=0 (break-before-make), then arbitrate per REQ-013/014 on the next edge: OWN if any req set, else IDLE.
REQ-023 gnt SHALL never have more than one bit set in any cycle.
REQ-024 Requests asserted or dropped during GAP SHALL be evaluated only at the GAP exit edge.
REQ-025 Simultaneous owner release and req[2] rise SHALL produce one GAP cycle, then grant to requester 2.

Reset
REQ-026 While rst_n is low: state=IDLE, gnt=0, leds=0, tick=0, busy=0, tick counter=0, hold counter=0, round-robin pointer selects requester 0.
REQ-027 Reset asserted mid-OWN SHALL clear gnt and leds asynchronously, without waiting for a clock edge.
REQ-028 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-029 TICK_DIV=4: release reset, count cycles -> tick pulses exactly once every 4 cycles, 1 cycle wide.
REQ-030 req=3'b001, pat0=4'b0101 -> gnt=3'b001 one edge later, leds=4'b0101 thereafter; drop req -> one GAP cycle (gnt=0, leds=0), then IDLE, busy=0.
REQ-031 TICK_DIV=4, HOLD_TICKS=2, req=3'b011 held -> grant 0 first, swaps to 1 after 2 ticks with one GAP cycle, then back to 0 after 2 more ticks; gnt one-hot throughout.
REQ-032 Owner 1 at hold 0, assert req[2] with pat2=4'b1111 -> GAP next cycle, gnt=3'b100 and leds=4'b1111 the cycle after; req[0]/req[1] held high never regain the LEDs until req[2] drops.
REQ-033 Owner 0 drops req on the same edge req[2] rises -> exactly one GAP cycle, then gnt=3'b100.
REQ-034 Assert rst_n low mid-OWN between edges -> gnt=0, leds=0, busy=0 immediately; after release with req=3'b011 -> requester 0 granted first.
